// File: rtl/relu_share_sched_pkg.sv
// rtl/relu_share_sched_pkg.sv - shared widths and the ReLU/saturation function for the scheduler
package relu_sched_pkg;

    localparam int MAX_DW = 32;
    localparam int MAX_W  = 2 * MAX_DW;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // x is a zero-extended 2*dw-bit signed sum; result is right-aligned in dw bits
    function automatic logic [MAX_DW-1:0] relu_sat(input logic [MAX_W-1:0] x,
                                                   input int dw, input int wiw);
        logic [MAX_W-1:0] dmask;
        logic [MAX_W-1:0] imask;
        logic [MAX_W-1:0] res;
        dmask = (MAX_W'(1) << dw) - MAX_W'(1);
        imask = (MAX_W'(1) << (wiw + 1)) - MAX_W'(1);
        if (((x >> (2 * dw - 1)) & MAX_W'(1)) != '0) begin
            res = '0;
        end else if (((x >> (2 * dw - 1 - wiw)) & imask) != '0) begin
            res = dmask >> 1;
        end else begin
            res = (x >> (dw - wiw)) & dmask;
        end
        return res[MAX_DW-1:0];
    endfunction

endpackage

// File: rtl/relu_share_sched_if.sv
// rtl/relu_share_sched_if.sv - request/grant and result bus between neurons, scheduler and collector
interface relu_share_sched_if #(
    parameter int NUM_NEURONS = 4,
    parameter int dataWidth   = 16
);
    import relu_sched_pkg::*;

    localparam int IDX_W = idx_width(NUM_NEURONS);

    logic                              layer_start;
    logic [NUM_NEURONS-1:0]            req;
    logic [NUM_NEURONS*2*dataWidth-1:0] sum;
    logic [NUM_NEURONS-1:0]            gnt;
    logic                              out_valid;
    logic [dataWidth-1:0]              out_data;
    logic [IDX_W-1:0]                  out_idx;
    logic                              out_ready;
    logic [NUM_NEURONS-1:0]            served;
    logic                              layer_done;

    modport master (
        output layer_start, req, sum, out_ready,
        input  gnt, out_valid, out_data, out_idx, served, layer_done
    );

    modport slave (
        input  layer_start, req, sum, out_ready,
        output gnt, out_valid, out_data, out_idx, served, layer_done
    );

endinterface

// File: rtl/relu_share_sched_rr_arbiter.sv
// rtl/relu_share_sched_rr_arbiter.sv - round-robin one-hot arbiter with internal rotating pointer
module rr_arbiter
    import relu_sched_pkg::*;
#(
    parameter int NUM_NEURONS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_NEURONS-1:0] elig,
    output logic [NUM_NEURONS-1:0] gnt
);

    localparam int IDX_W = idx_width(NUM_NEURONS);

    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       ptr_d;
    logic [NUM_NEURONS-1:0] rot;

    // Walk from the farthest candidate back to ptr so the nearest eligible one wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        rot   = '0;
        if (en && !rst) begin
            for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
                rot = elig >> ((int'(ptr_q) + k) % NUM_NEURONS);
                if (rot[0]) begin
                    gnt   = NUM_NEURONS'(1) << ((int'(ptr_q) + k) % NUM_NEURONS);
                    ptr_d = IDX_W'((int'(ptr_q) + k + 1) % NUM_NEURONS);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/relu_share_sched.sv
// rtl/relu_share_sched.sv - shares one registered ReLU/saturation stage among a layer of neurons
module relu_share_sched
    import relu_sched_pkg::*;
#(
    parameter int NUM_NEURONS    = 4,
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4
) (
    input  logic              clk,
    input  logic              rst,
    relu_share_sched_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_NEURONS);
    localparam int SW    = 2 * dataWidth;

    logic                   s1_valid_q, s1_valid_d;
    logic [SW-1:0]          s1_sum_q, s1_sum_d;
    logic [IDX_W-1:0]       s1_idx_q, s1_idx_d;
    logic                   out_valid_q, out_valid_d;
    logic [dataWidth-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]       out_idx_q, out_idx_d;
    logic [NUM_NEURONS-1:0] served_q, served_d;
    logic                   layer_done_q, layer_done_d;

    logic                   s2_adv;
    logic                   accept;
    logic [NUM_NEURONS-1:0] elig;
    logic [NUM_NEURONS-1:0] gnt;
    logic [IDX_W-1:0]       gnt_idx;

    assign s2_adv = !out_valid_q || bus.out_ready;
    assign accept = !s1_valid_q || s2_adv;
    assign elig   = bus.req & ~served_q;

    rr_arbiter #(.NUM_NEURONS(NUM_NEURONS)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .elig (elig),
        .gnt  (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (gnt == (NUM_NEURONS'(1) << i)) gnt_idx = IDX_W'(i);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_idx_d    = s1_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            s1_valid_d  = 1'b0;
            if (s1_valid_q) begin
                out_data_d = dataWidth'(relu_sat(MAX_W'(s1_sum_q), dataWidth, weightIntWidth));
                out_idx_d  = s1_idx_q;
            end
        end
        if (|gnt) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = SW'(bus.sum >> (int'(gnt_idx) * SW));
            s1_idx_d   = gnt_idx;
        end
        // A grant in the layer_start cycle belongs to the new layer.
        served_d     = (bus.layer_start ? '0 : served_q) | gnt;
        layer_done_d = !bus.layer_start &&
                       (layer_done_q || (&served_d && !s1_valid_d && !out_valid_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            served_q     <= '0;
            layer_done_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            s1_idx_q     <= s1_idx_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            served_q     <= served_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.served     = served_q;
    assign bus.layer_done = layer_done_q;

endmodule

// File: tb/tb_relu_share_sched.sv
// tb/tb_relu_share_sched.sv - directed vectors plus randomized run against a transaction-level model
module tb_relu_share_sched;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int WIW = 4;
    localparam int SW  = 2 * DW;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        int          idx;
        int          t;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    relu_share_sched_if #(.NUM_NEURONS(N), .dataWidth(DW)) bus ();

    relu_share_sched #(.NUM_NEURONS(N), .dataWidth(DW), .weightIntWidth(WIW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_sum(input int i, input logic [31:0] v);
        bus.sum[i*SW +: SW] = v;
    endtask

    task automatic do_reset;
        rst             = 1'b1;
        bus.req         = '0;
        bus.layer_start = 1'b0;
        bus.out_ready   = 1'b1;
        bus.sum         = '0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic pulse_layer_start;
        bus.layer_start = 1'b1;
        step;
        bus.layer_start = 1'b0;
    endtask

    function automatic logic [15:0] ref_relu(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) return 16'h0000;
        if (v >= 64'sd134217728) return 16'h7fff;
        return 16'(v / 4096);
    endfunction

    function automatic logic [31:0] rand_sum;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom_range(0, 32'h07ff_ffff);
            2:       return 32'h8000_0000 | $urandom;
            default: return 32'h07ff_fffe + $urandom_range(0, 3);
        endcase
    endfunction

    vec_t vecs[8];
    int   exp_gnt4[9];
    int   exp_ov4[9];
    int   exp_idx4[9];

    initial begin
        vecs[0] = '{32'h0001_2000, 16'h0012};
        vecs[1] = '{32'h0800_0000, 16'h7fff};
        vecs[2] = '{32'hffff_f000, 16'h0000};
        vecs[3] = '{32'h07ff_ffff, 16'h7fff};
        vecs[4] = '{32'h0400_0000, 16'h4000};
        vecs[5] = '{32'h8000_0000, 16'h0000};
        vecs[6] = '{32'h00ab_cdef, 16'h0abc};
        vecs[7] = '{32'h1234_5678, 16'h7fff};
        exp_gnt4 = '{1, 2, 0, 0, 0, 4, 0, 0, 0};
        exp_ov4  = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        exp_idx4 = '{0, 0, 0, 0, 0, 0, 1, 2, 0};

        do_reset;
        #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_served", bus.served, 0);
        check("rst_layer_done", bus.layer_done, 0);

        // All four request with ptr at 0: back-to-back grants and results
        for (int i = 0; i < N; i++) set_sum(i, 32'((i + 1) << 12));
        bus.req = 4'hf;
        for (int c = 0; c < 7; c++) begin
            #1;
            check("rr_gnt", bus.gnt, (c < 4) ? (64'd1 << c) : 64'd0);
            check("rr_out_valid", bus.out_valid, (c >= 2 && c < 6) ? 1 : 0);
            if (c >= 2 && c < 6) begin
                check("rr_out_idx", bus.out_idx, c - 2);
                check("rr_out_data", bus.out_data, c - 1);
            end
            check("rr_layer_done", bus.layer_done, (c == 6) ? 1 : 0);
            step;
            if (c < 4) bus.req[c] = 1'b0;
        end

        // Single-neuron transfers through the ReLU table, latency 2
        for (int v = 0; v < 8; v++) begin
            pulse_layer_start;
            bus.req = 4'(1 << (v % N));
            set_sum(v % N, vecs[v].sum);
            #1;
            check("tbl_gnt", bus.gnt, 64'd1 << (v % N));
            step;
            bus.req = '0;
            #1;
            check("tbl_lat_ov", bus.out_valid, 0);
            step;
            check("tbl_out_valid", bus.out_valid, 1);
            check("tbl_out_data", bus.out_data, vecs[v].exp);
            check("tbl_out_idx", bus.out_idx, v % N);
        end

        // Backpressure: three pending, only two may enter before the stall
        pulse_layer_start;
        for (int i = 0; i < 3; i++) set_sum(i, 32'((i + 5) << 12));
        bus.out_ready = 1'b0;
        bus.req       = 4'b0111;
        for (int c = 0; c < 9; c++) begin
            bus.out_ready = (c >= 5);
            #1;
            check("bp_gnt", bus.gnt, exp_gnt4[c]);
            check("bp_out_valid", bus.out_valid, exp_ov4[c]);
            if (exp_ov4[c] != 0) begin
                check("bp_out_idx", bus.out_idx, exp_idx4[c]);
                check("bp_out_data", bus.out_data, exp_idx4[c] + 5);
            end
            step;
            bus.req = bus.req & ~4'(exp_gnt4[c]);
        end

        // Duplicate request from a served neuron waits for the next layer
        bus.req = 4'b0100;
        set_sum(2, 32'h0000_3000);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("dup_gnt", bus.gnt, 0);
            step;
        end
        bus.layer_start = 1'b1;
        #1;
        check("dup_ls_gnt", bus.gnt, 0);
        step;
        bus.layer_start = 1'b0;
        #1;
        check("dup_regnt", bus.gnt, 4'b0100);
        step;
        bus.req = '0;
        #1;
        check("dup_served", bus.served, 4'b0100);
        step;
        step;

        // Reset with both stages full restarts the ptr=0 order
        bus.out_ready = 1'b0;
        bus.req       = 4'b0011;
        #1;
        check("rs_gnt0", bus.gnt, 4'b0001);
        step;
        bus.req[0] = 1'b0;
        #1;
        check("rs_gnt1", bus.gnt, 4'b0010);
        step;
        rst     = 1'b1;
        bus.req = 4'hf;
        #1;
        check("rs_stall_gnt", bus.gnt, 0);
        check("rs_full_ov", bus.out_valid, 1);
        step;
        check("rs_out_valid", bus.out_valid, 0);
        check("rs_served", bus.served, 0);
        check("rs_gnt", bus.gnt, 0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            #1;
            check("rs_order", bus.gnt, 64'd1 << k);
            step;
            bus.req[k] = 1'b0;
        end

        // Randomized traffic against the transaction-level model
        do_reset;
        begin
            item_t       q[$];
            logic [31:0] cur_sum[N];
            logic [3:0]  req_r;
            logic [3:0]  m_served;
            logic [3:0]  elig;
            logic [3:0]  egnt;
            logic        m_ld;
            logic        ls;
            logic        rdy;
            logic        eov;
            int          m_ptr;
            int          w;
            req_r    = '0;
            m_served = '0;
            m_ld     = 1'b0;
            m_ptr    = 0;
            for (int i = 0; i < N; i++) cur_sum[i] = '0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                ls  = ($urandom_range(0, 15) == 0) || (m_ld && $urandom_range(0, 1) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                for (int n = 0; n < N; n++) begin
                    if (!req_r[n] && $urandom_range(0, 3) == 0) begin
                        req_r[n]   = 1'b1;
                        cur_sum[n] = rand_sum();
                    end
                    set_sum(n, cur_sum[n]);
                end
                bus.req         = req_r;
                bus.layer_start = ls;
                bus.out_ready   = rdy;
                #1;
                elig = req_r & ~m_served;
                eov  = (q.size() > 0) && (q[0].t + 2 <= cyc);
                w    = -1;
                if (q.size() < 2 || rdy) begin
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                end
                egnt = (w >= 0) ? 4'(1 << w) : 4'd0;
                check("rnd_gnt", bus.gnt, egnt);
                check("rnd_out_valid", bus.out_valid, eov);
                if (eov) begin
                    check("rnd_out_data", bus.out_data, q[0].d);
                    check("rnd_out_idx", bus.out_idx, q[0].idx);
                end
                check("rnd_served", bus.served, m_served);
                check("rnd_layer_done", bus.layer_done, m_ld);
                if (eov && rdy) void'(q.pop_front());
                if (w >= 0) begin
                    q.push_back('{ref_relu(cur_sum[w]), w, cyc});
                    m_ptr = (w + 1) % N;
                end
                m_served = (ls ? 4'd0 : m_served) | egnt;
                m_ld     = !ls && (m_ld || (m_served == 4'hf && q.size() == 0));
                step;
                if (w >= 0) req_r[w] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
